// File: rtl/wb_stage.sv
// wb_stage: MIPS writeback stage. It holds the M/W pipeline register, picks the
// regfile write data, and owns the architectural HI/LO pair.
module wb_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m_valid,
  input  logic [5:0]  m_aluop,
  input  logic        m_rwe,
  input  logic        m_rwd,
  input  logic        m_rdst,
  input  logic [31:0] m_insn,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_hi,
  input  logic [31:0] m_lo,
  input  logic [31:0] m_dmem,
  input  logic        flush,
  output logic [4:0]  d,
  output logic [31:0] rd,
  output logic        rwe_wb,
  output logic        fwd_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] OP_MULT = 6'b000010;
  localparam logic [5:0] OP_DIV  = 6'b000011;
  localparam logic [5:0] OP_MFHI = 6'b000100;
  localparam logic [5:0] OP_MFLO = 6'b000101;
  localparam logic [5:0] OP_JALR = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b010011;
  localparam logic [5:0] OP_LB   = 6'b010101;
  localparam logic [5:0] OP_LUI  = 6'b010110;
  localparam logic [5:0] OP_LBU  = 6'b011000;
  localparam logic [5:0] OP_JAL  = 6'b100000;
  localparam logic [5:0] OP_NOP  = 6'b100001;

  logic        cap;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [7:0]  ld_byte;
  logic [31:0] pc_link;
  logic [4:0]  w_dst;
  logic [31:0] w_data;
  logic        w_we;
  logic        hilo_we;
  logic        unused_insn_bits;

  assign cap     = m_valid & ~flush;
  assign rt_f    = m_insn[20:16];
  assign rd_f    = m_insn[15:11];
  assign pc_link = m_pc + 32'd8;
  assign hilo_we = (m_aluop == OP_MULT) || (m_aluop == OP_DIV);
  assign unused_insn_bits = ^{m_insn[31:21], m_insn[10:0]};

  // Big-endian byte lane select for LB/LBU.
  always_comb begin
    ld_byte = m_dmem[31:24];
    case (m_alu[1:0])
      2'b00: ld_byte = m_dmem[31:24];
      2'b01: ld_byte = m_dmem[23:16];
      2'b10: ld_byte = m_dmem[15:8];
      2'b11: ld_byte = m_dmem[7:0];
      default: ld_byte = m_dmem[31:24];
    endcase
  end

  // Destination, write enable and write data for the instruction being captured.
  // MFHI/MFLO read the HI/LO registers as they stand before this edge.
  always_comb begin
    w_dst  = m_rdst ? rd_f : rt_f;
    w_we   = m_rwe;
    w_data = m_rwd ? m_dmem : m_alu;
    case (m_aluop)
      OP_JAL: begin
        w_dst  = 5'd31;
        w_data = pc_link;
      end
      OP_JALR: begin
        w_dst  = (rd_f != 5'd0) ? rd_f : 5'd31;
        w_data = pc_link;
      end
      OP_MFHI: begin
        w_we   = 1'b1;
        w_data = hi;
      end
      OP_MFLO: begin
        w_we   = 1'b1;
        w_data = lo;
      end
      OP_MULT, OP_DIV, OP_NOP: w_we = 1'b0;
      OP_LW:   w_data = m_dmem;
      OP_LB:   w_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  w_data = {24'd0, ld_byte};
      OP_LUI:  w_data = m_alu;
      default: ;
    endcase
    if (w_dst == 5'd0) w_we = 1'b0;
  end

  // M/W register and HI/LO; a non-captured slot becomes a bubble with no write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d      <= 5'd0;
      rd     <= 32'd0;
      rwe_wb <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (cap) begin
      d      <= w_dst;
      rd     <= w_data;
      rwe_wb <= w_we;
      if (hilo_we) begin
        hi <= m_hi;
        lo <= m_lo;
      end
    end else begin
      d      <= 5'd0;
      rd     <= 32'd0;
      rwe_wb <= 1'b0;
    end
  end

  assign fwd_valid = rwe_wb;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        m_valid, m_rwe, m_rwd, m_rdst, flush;
  logic [5:0]  m_aluop;
  logic [31:0] m_insn, m_pc, m_alu, m_hi, m_lo, m_dmem;
  logic [4:0]  d;
  logic [31:0] rd, hi, lo;
  logic        rwe_wb, fwd_valid;

  typedef struct {
    string       tag;
    logic [4:0]  d;
    logic [31:0] rd;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;

  localparam logic [5:0] ADD = 6'b000000, MULT = 6'b000010, MFHI = 6'b000100,
                         MFLO = 6'b000101, JALR = 6'b010001, LW = 6'b010011,
                         LB = 6'b010101, LUI = 6'b010110, LBU = 6'b011000,
                         JAL = 6'b100000, NOP = 6'b100001;

  wb_stage dut (
    .clock(clock), .reset_n(reset_n), .m_valid(m_valid), .m_aluop(m_aluop),
    .m_rwe(m_rwe), .m_rwd(m_rwd), .m_rdst(m_rdst), .m_insn(m_insn),
    .m_pc(m_pc), .m_alu(m_alu), .m_hi(m_hi), .m_lo(m_lo), .m_dmem(m_dmem),
    .flush(flush), .d(d), .rd(rd), .rwe_wb(rwe_wb), .fwd_valid(fwd_valid),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] mk_insn(input logic [4:0] rt, input logic [4:0] rdf);
    return {11'd0, rt, rdf, 11'd0};
  endfunction

  // Drive one slot, push its expected result, clock it, then pop and compare.
  task automatic step(input string tag, input logic [5:0] op, input logic rwe,
                      input logic rwd, input logic rdst, input logic [31:0] insn,
                      input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] hin, input logic [31:0] lon,
                      input logic [31:0] dmem, input logic valid, input logic fl,
                      input logic [4:0] ed, input logic [31:0] erd, input logic ewe,
                      input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    m_aluop = op; m_rwe = rwe; m_rwd = rwd; m_rdst = rdst; m_insn = insn;
    m_pc = pc; m_alu = alu; m_hi = hin; m_lo = lon; m_dmem = dmem;
    m_valid = valid; flush = fl;
    e.tag = tag; e.d = ed; e.rd = erd; e.we = ewe; e.hi = ehi; e.lo = elo;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".rwe_wb"}, {31'd0, rwe_wb}, {31'd0, e.we});
      check({e.tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, e.we});
      if (e.we) begin
        check({e.tag, ".d"}, {27'd0, d}, {27'd0, e.d});
        check({e.tag, ".rd"}, rd, e.rd);
      end
      check({e.tag, ".hi"}, hi, e.hi);
      check({e.tag, ".lo"}, lo, e.lo);
    end
  endtask

  initial begin
    logic [31:0] lb_exp [4];
    logic [31:0] lbu_exp[4];
    lb_exp  = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F, 32'h00000001};
    lbu_exp = '{32'h00000080, 32'h000000FF, 32'h0000007F, 32'h00000001};

    reset_n = 1'b0; m_valid = 1'b0; flush = 1'b0; m_aluop = NOP; m_rwe = 1'b0;
    m_rwd = 1'b0; m_rdst = 1'b0; m_insn = '0; m_pc = '0; m_alu = '0;
    m_hi = '0; m_lo = '0; m_dmem = '0;
    #12;
    check("reset.d", {27'd0, d}, 32'd0);
    check("reset.rd", rd, 32'd0);
    check("reset.rwe_wb", {31'd0, rwe_wb}, 32'd0);
    check("reset.fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    step("addu_r5", ADD, 1, 0, 1, mk_insn(5'd0, 5'd5), 32'h0, 32'h12345678, 0, 0, 0, 1, 0,
         5'd5, 32'h12345678, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.rwe_wb", {31'd0, rwe_wb}, 32'd0);
    check("midreset.rd", rd, 32'd0);
    m_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    step("flush_mult", MULT, 0, 0, 1, mk_insn(5'd0, 5'd0), 0, 0, 32'h1, 32'h2, 0, 1, 1,
         5'd0, 32'd0, 0, 32'd0, 32'd0);
    step("mfhi_after_flush", MFHI, 0, 0, 1, mk_insn(5'd0, 5'd4), 0, 0, 0, 0, 0, 1, 0,
         5'd4, 32'd0, 1, 32'd0, 32'd0);

    for (int k = 0; k < 4; k++)
      step($sformatf("lb_%0d", k), LB, 1, 1, 0, mk_insn(5'd8, 5'd0), 0, 32'h1000 | k,
           0, 0, 32'h80FF7F01, 1, 0, 5'd8, lb_exp[k], 1, 0, 0);
    for (int k = 0; k < 4; k++)
      step($sformatf("lbu_%0d", k), LBU, 1, 1, 0, mk_insn(5'd9, 5'd0), 0, 32'h2000 | k,
           0, 0, 32'h80FF7F01, 1, 0, 5'd9, lbu_exp[k], 1, 0, 0);

    step("jal", JAL, 1, 0, 0, mk_insn(5'd3, 5'd7), 32'h00400010, 32'h55, 0, 0, 0, 1, 0,
         5'd31, 32'h00400018, 1, 0, 0);
    step("jalr_wrap", JALR, 1, 0, 1, mk_insn(5'd0, 5'd0), 32'hFFFFFFFC, 32'h55, 0, 0, 0, 1, 0,
         5'd31, 32'h00000004, 1, 0, 0);
    step("jalr_rd", JALR, 1, 0, 1, mk_insn(5'd0, 5'd12), 32'h00001000, 32'h55, 0, 0, 0, 1, 0,
         5'd12, 32'h00001008, 1, 0, 0);

    step("mult", MULT, 0, 0, 1, mk_insn(5'd0, 5'd0), 0, 0, 32'hA, 32'hB, 0, 1, 0,
         5'd0, 32'd0, 0, 32'hA, 32'hB);
    step("mfhi", MFHI, 0, 0, 1, mk_insn(5'd0, 5'd2), 0, 0, 32'h77, 32'h88, 0, 1, 0,
         5'd2, 32'hA, 1, 32'hA, 32'hB);
    step("mflo", MFLO, 0, 0, 1, mk_insn(5'd0, 5'd3), 0, 0, 32'h77, 32'h88, 0, 1, 0,
         5'd3, 32'hB, 1, 32'hA, 32'hB);
    step("bubble_mult", MULT, 0, 0, 1, mk_insn(5'd0, 5'd0), 0, 0, 32'h99, 32'h99, 0, 0, 0,
         5'd0, 32'd0, 0, 32'hA, 32'hB);

    step("addi_r0", ADD, 1, 0, 0, mk_insn(5'd0, 5'd9), 0, 32'h1234, 0, 0, 0, 1, 0,
         5'd0, 32'd0, 0, 32'hA, 32'hB);
    step("invalid_slot", ADD, 1, 0, 1, mk_insn(5'd0, 5'd6), 0, 32'h1234, 0, 0, 0, 0, 0,
         5'd0, 32'd0, 0, 32'hA, 32'hB);
    step("lw_misaligned", LW, 1, 1, 0, mk_insn(5'd10, 5'd0), 0, 32'h3002, 0, 0, 32'hDEADBEEF,
         1, 0, 5'd10, 32'hDEADBEEF, 1, 32'hA, 32'hB);
    step("lui", LUI, 1, 0, 0, mk_insn(5'd11, 5'd0), 0, 32'hABCD0000, 0, 0, 32'h1, 1, 0,
         5'd11, 32'hABCD0000, 1, 32'hA, 32'hB);
    step("alu_rwd_mem", ADD, 1, 1, 1, mk_insn(5'd0, 5'd13), 0, 32'h5, 0, 0, 32'hCAFEF00D,
         1, 0, 5'd13, 32'hCAFEF00D, 1, 32'hA, 32'hB);
    step("unknown_op", 6'b111111, 1, 0, 1, mk_insn(5'd0, 5'd14), 0, 32'h600D, 0, 0, 32'h1,
         1, 0, 5'd14, 32'h600D, 1, 32'hA, 32'hB);
    step("nop", NOP, 1, 0, 1, mk_insn(5'd0, 5'd15), 0, 32'h1, 0, 0, 0, 1, 0,
         5'd0, 32'd0, 0, 32'hA, 32'hB);
    step("b2b_r7_a", ADD, 1, 0, 1, mk_insn(5'd0, 5'd7), 0, 32'h11111111, 0, 0, 0, 1, 0,
         5'd7, 32'h11111111, 1, 32'hA, 32'hB);
    step("b2b_r7_b", ADD, 1, 0, 1, mk_insn(5'd0, 5'd7), 0, 32'h22222222, 0, 0, 0, 1, 0,
         5'd7, 32'h22222222, 1, 32'hA, 32'hB);

    m_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("final_reset.hi", hi, 32'd0);
    check("final_reset.rwe_wb", {31'd0, rwe_wb}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage MIPS pipeline: the write side of the register file whose read side lives in decode. Registers the memory-stage result (M/W pipeline register), selects ALU, load or link data, extracts/extends byte loads, owns the HI/LO pair for MULT/DIV/MFHI/MFLO, and drives the regfile write port (`d`, `rd`, `rwe_wb`). It also exports the pending write for decode-stage forwarding.

## Interface
- No parameters. Widths are fixed: 32-bit datapath, 5-bit register index, 6-bit aluop.
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_valid  in  1  memory-stage slot holds a real instruction.
- m_aluop  in  6  decode aluop code: ADD 000000, MULT 000010, DIV 000011, MFHI 000100, MFLO 000101, JALR 010001, LW 010011, LB 010101, LUI 010110, LBU 011000, JAL 100000, NOP 100001.
- m_rwe  in  1  regfile write enable from decode.
- m_rwd  in  1  write-data select: 0 = ALU, 1 = data memory.
- m_rdst  in  1  destination select: 1 = rd field, 0 = rt field.
- m_insn  in  32  instruction word; rt = [20:16], rd = [15:11].
- m_pc  in  32  PC of the instruction.
- m_alu  in  32  ALU result, or byte address for loads.
- m_hi, m_lo  in  32 each  64-bit MULT/DIV result halves.
- m_dmem  in  32  data-memory read word, big-endian.
- flush  in  1  kill the instruction being captured this edge.
- d  out  5  regfile write index.
- rd  out  32  regfile write data.
- rwe_wb  out  1  regfile write enable.
- fwd_valid  out  1  equals rwe_wb; marks `d`/`rd` as forwardable.
- hi, lo  out  32 each  architectural HI/LO.

## Operation
- The capture condition `cap` = m_valid & ~flush. On each rising edge, the W register loads the inputs when `cap` is true. When `cap` is false, it loads a bubble: valid = 0, and no write is performed.
- Destination index:
  - JAL: 31.
  - JALR: rd field if nonzero, else 31.
  - Otherwise: m_rdst ? rd field : rt field.
- Write enable:
  - MFHI/MFLO: forced to 1 regardless of m_rwe (decode drives 0 for these).
  - MULT/DIV/NOP: forced to 0.
  - Otherwise: m_rwe.
  - Any write whose destination is 0 is suppressed (rwe_wb = 0).
- Write data:
  - JAL/JALR: m_pc + 8, with 32-bit wrap (0xFFFFFFFC → 0x00000004).
  - MFHI: the HI value. MFLO: the LO value.
  - LW: m_dmem. The address must be word-aligned; misaligned LW writes m_dmem unmodified.
  - LB/LBU: byte lane from m_alu[1:0], big-endian (00 → [31:24], 01 → [23:16], 10 → [15:8], 11 → [7:0]). LB sign-extends; LBU zero-extends.
  - LUI: m_alu, passed through.
  - Any other opcode: m_rwd ? m_dmem : m_alu.
- HI/LO:
  - On a capture edge with aluop MULT or DIV, hi ← m_hi and lo ← m_lo.
  - Flushed or bubbled MULT/DIV never update HI/LO.
- MFHI/MFLO latch the HI/LO value held before their capture edge. A MULT immediately followed by MFHI therefore returns the new product; no interlock is needed.
- Unknown aluop: treated as a normal ALU op governed by m_rwe and m_rwd, never as X.

## Timing
- Latency: inputs sampled at edge N. `d`, `rd` and `rwe_wb` are valid from just after edge N until edge N+1. The regfile commits at edge N+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (asynchronous, takes effect immediately regardless of clock): d = 0, rd = 0, rwe_wb = 0, fwd_valid = 0, hi = 0, lo = 0.
- Reset asserted mid-operation: the in-flight write is dropped, HI/LO clear, and no write occurs until the first capture after reset_n deasserts.
- Throughput: one instruction per cycle, with no stall input. Back-to-back writes to the same register each commit in order.
- flush and m_valid are sampled only at the edge. Flush wins over valid.

## Test plan
- Reset, then ADDU to rd = 5 with m_alu = 0x12345678 → one cycle later d = 5, rd = 0x12345678, rwe_wb = 1. Assert reset_n mid-cycle → rwe_wb drops to 0 asynchronously.
- LB vs LBU with m_dmem = 0x80FF7F01, m_alu[1:0] = 00, 01, 10, 11:
  - LB → rd = 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001.
  - LBU → rd = 0x00000080, 0x000000FF, 0x0000007F, 0x00000001.
- JAL with m_pc = 0x00400010 → d = 31, rd = 0x00400018. JALR with rd field = 0 and m_pc = 0xFFFFFFFC → d = 31, rd = 0x00000004.
- MULT (m_hi = 0xA, m_lo = 0xB), then MFHI to rd = 2 on the next cycle, then MFLO to rd = 3 → rd = 0xA then 0xB, rwe_wb = 1 for both. MULT itself gives rwe_wb = 0.
- Flushed MULT with m_hi = 0x1, followed by MFHI → HI unchanged (0 after reset), rd = 0.
- ADDI to rt = 0 with m_rwe = 1 → rwe_wb = 0. An m_valid = 0 slot → rwe_wb = 0 and fwd_valid = 0.
